// File: rtl/prim_flop_pipe_en.sv
// prim_flop_pipe_en: elastic Depth-stage valid/ready register slice with bubble collapse and flush.
// Define PRIM_FLOP_PIPE_DUP_EN to add shadow copies of every register and a sticky err_o.

module prim_sec_anchor_buf #(
   parameter int unsigned Width = 1
) (
   input  logic [Width-1:0] din,
   output logic [Width-1:0] dout
);
   assign dout = din;
endmodule

module prim_flop_pipe_en #(
   parameter int unsigned     Width      = 32,
   parameter int unsigned     Depth      = 2,
   parameter logic [Width-1:0] ResetValue = '0,
   parameter bit              EnSecBuf   = 1'b0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [Width-1:0]             data_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [Width-1:0]             data_o,
   output logic [$clog2(Depth+1)-1:0]   occupancy_o,
   output logic                         err_o
);
   localparam int unsigned OccW = $clog2(Depth + 1);
   logic [Depth-1:0] v, en, src_v;
   logic [Depth:0]   en_chain;
   logic [Width-1:0] d     [Depth];
   logic [Width-1:0] src_d [Depth];
   // A stage may load when it or any stage downstream of it is empty, or the sink takes a beat
   always_comb begin
      en_chain = '0;
      en_chain[Depth] = ready_i;
      for (int k = Depth - 1; k >= 0; k--) en_chain[k] = ~v[k] | en_chain[k+1];
   end
   assign ready_o = en_chain[0] & ~flush_i;
   if (EnSecBuf) begin : g_sec
      prim_sec_anchor_buf #(.Width(Depth)) u_en_buf (.din(en_chain[Depth-1:0]), .dout(en));
   end else begin : g_nosec
      assign en = en_chain[Depth-1:0];
   end
   for (genvar k = 0; k < Depth; k++) begin : g_src
      if (k == 0) begin : g_in
         assign src_v[k] = valid_i & ~flush_i;
         assign src_d[k] = data_i;
      end else begin : g_mid
         assign src_v[k] = v[k-1];
         assign src_d[k] = d[k-1];
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v <= '0;
         for (int k = 0; k < Depth; k++) d[k] <= ResetValue;
      end else begin
         for (int k = 0; k < Depth; k++) begin
            v[k] <= ~flush_i & (en[k] ? src_v[k] : v[k]);
            if (en[k] & src_v[k] & ~flush_i) d[k] <= src_d[k];
         end
      end
   end
   assign valid_o = v[Depth-1];
   assign data_o  = d[Depth-1];
   always_comb begin
      occupancy_o = '0;
      for (int k = 0; k < Depth; k++) occupancy_o = occupancy_o + OccW'(v[k]);
   end
`ifdef PRIM_FLOP_PIPE_DUP_EN
   logic [Depth-1:0] v_s;
   logic [Width-1:0] d_s [Depth];
   logic             mismatch, err;
   // Shadows share the primary enables and sources so any divergence means a corrupted flop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v_s <= '0;
         err <= 1'b0;
         for (int k = 0; k < Depth; k++) d_s[k] <= ResetValue;
      end else begin
         err <= err | mismatch;
         for (int k = 0; k < Depth; k++) begin
            v_s[k] <= ~flush_i & (en[k] ? src_v[k] : v_s[k]);
            if (en[k] & src_v[k] & ~flush_i) d_s[k] <= src_d[k];
         end
      end
   end
   always_comb begin
      mismatch = v != v_s;
      for (int k = 0; k < Depth; k++) mismatch = mismatch | (d[k] != d_s[k]);
   end
   assign err_o = err;
`else
   assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_prim_flop_pipe_en.sv
// tb_prim_flop_pipe_en: randomized and directed checks of prim_flop_pipe_en against a beat-queue model.
module tb_prim_flop_pipe_en;
   localparam int W = 32;
   localparam int D = 2;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, valid = 1'b0, ready = 1'b0;
   logic vo, ro, err;
   logic [W-1:0] din = '0, dout;
   logic [$clog2(D+1)-1:0] occ;
   int passed = 0, total = 0, cyc = 0;
   // Each beat remembers the earliest edge count at which it may sit at the output
   typedef struct {logic [W-1:0] d; int avail;} beat_t;
   beat_t q[$];
   always #5 clk = ~clk;
   prim_flop_pipe_en #(.Width(W), .Depth(D)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(ro),
      .data_i(din), .valid_o(vo), .ready_i(ready), .data_o(dout), .occupancy_o(occ), .err_o(err)
   );
   function automatic bit exp_valid();
      return q.size() > 0 && q[0].avail <= cyc;
   endfunction
   function automatic bit exp_ready();
      return (q.size() < D || ready) && !flush;
   endfunction
   task automatic tick();
      bit acc = exp_ready() && valid;
      bit pop = exp_valid() && ready;
      bit f = flush;
      logic [W-1:0] dd = din;
      @(posedge clk);
      cyc++;
      if (f) q.delete();
      else begin
         if (pop) begin
            void'(q.pop_front());
            if (q.size() > 0 && q[0].avail < cyc) q[0].avail = cyc;
         end
         if (acc) q.push_back('{dd, cyc + D - 1});
      end
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      cyc = 0;
   endtask
   task automatic test_reset();
      do_reset();
      #1;
      total++; if (vo !== 1'b0) $display("FAIL reset valid_o: got %b want 0", vo); else passed++;
      total++; if (dout !== '0) $display("FAIL reset data_o: got %h want 0", dout); else passed++;
      total++; if (ro !== 1'b1) $display("FAIL reset ready_o: got %b want 1", ro); else passed++;
      total++; if (occ !== '0) $display("FAIL reset occupancy_o: got %0d want 0", occ); else passed++;
      total++; if (err !== 1'b0) $display("FAIL reset err_o: got %b want 0", err); else passed++;
      @(negedge clk);
   endtask
   task automatic test_stream();
      int first = -1, last = -1;
      logic [W-1:0] got[$];
      bit ok;
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         valid = i < 8;
         din = i < 8 ? W'(i + 1) : '0;
         #1;
         total++; if (vo !== exp_valid()) $display("FAIL stream valid_o cyc %0d: got %b want %b", i, vo, exp_valid()); else passed++;
         if (exp_valid()) begin
            total++; if (dout !== q[0].d) $display("FAIL stream data_o cyc %0d: got %h want %h", i, dout, q[0].d); else passed++;
         end
         if (vo === 1'b1) begin
            if (first < 0) first = i;
            last = i;
            got.push_back(dout);
         end
         tick();
      end
      total++; if (first != 2) $display("FAIL stream latency: got first valid at %0d want 2", first); else passed++;
      ok = got.size() == 8 && last == first + 7;
      for (int i = 0; i < got.size() && i < 8; i++) ok = ok && got[i] == W'(i + 1);
      total++; if (!ok) $display("FAIL stream order: got %0d beats span %0d..%0d want 8 beats 1..8 consecutive", got.size(), first, last); else passed++;
   endtask
   task automatic test_backpressure();
      do_reset();
      ready = 1'b0; valid = 1'b1; din = 32'hA;
      #1;
      total++; if (ro !== 1'b1) $display("FAIL bp ready_o empty: got %b want 1", ro); else passed++;
      tick();
      din = 32'hB;
      tick();
      din = 32'hC;
      #1;
      total++; if (ro !== 1'b0) $display("FAIL bp ready_o full: got %b want 0", ro); else passed++;
      total++; if (occ !== 2'd2) $display("FAIL bp occupancy full: got %0d want 2", occ); else passed++;
      tick();
      ready = 1'b1;
      #1;
      total++; if (ro !== 1'b1) $display("FAIL bp ready_o on release: got %b want 1", ro); else passed++;
      total++; if (dout !== 32'hA || vo !== 1'b1) $display("FAIL bp first out: got %b/%h want 1/a", vo, dout); else passed++;
      tick();
      valid = 1'b0;
      #1;
      total++; if (occ !== 2'd2) $display("FAIL bp occupancy after accept+output: got %0d want 2", occ); else passed++;
      total++; if (dout !== 32'hB || vo !== 1'b1) $display("FAIL bp second out: got %b/%h want 1/b", vo, dout); else passed++;
      tick();
      #1;
      total++; if (dout !== 32'hC || vo !== 1'b1) $display("FAIL bp third out: got %b/%h want 1/c", vo, dout); else passed++;
      tick();
      #1;
      total++; if (vo !== 1'b0) $display("FAIL bp drained valid_o: got %b want 0", vo); else passed++;
   endtask
   task automatic test_flush();
      bit seen = 1'b0;
      do_reset();
      ready = 1'b0; valid = 1'b1; din = 32'h1;
      tick();
      din = 32'h2;
      tick();
      flush = 1'b1; din = 32'hD;
      #1;
      total++; if (ro !== 1'b0) $display("FAIL flush ready_o during flush: got %b want 0", ro); else passed++;
      tick();
      flush = 1'b0; valid = 1'b0;
      #1;
      total++; if (occ !== '0) $display("FAIL flush occupancy: got %0d want 0", occ); else passed++;
      total++; if (vo !== 1'b0) $display("FAIL flush valid_o: got %b want 0", vo); else passed++;
      total++; if (ro !== 1'b1) $display("FAIL flush ready_o after: got %b want 1", ro); else passed++;
      ready = 1'b1;
      repeat (4) begin
         #1;
         if (vo !== 1'b0) seen = 1'b1;
         tick();
      end
      total++; if (seen) $display("FAIL flush leak: got a beat after flush want none"); else passed++;
   endtask
   task automatic test_reset_mid();
      do_reset();
      ready = 1'b0; valid = 1'b1; din = 32'h5;
      tick();
      din = 32'h6;
      tick();
      valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (vo !== 1'b0) $display("FAIL midreset valid_o: got %b want 0", vo); else passed++;
      total++; if (dout !== '0) $display("FAIL midreset data_o: got %h want 0", dout); else passed++;
      total++; if (occ !== '0) $display("FAIL midreset occupancy: got %0d want 0", occ); else passed++;
      total++; if (ro !== 1'b1) $display("FAIL midreset ready_o: got %b want 1", ro); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      cyc = 0;
   endtask
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         valid = 1'($urandom_range(0, 1));
         ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 19) == 0;
         din = $urandom;
         #1;
         total++; if (ro !== exp_ready()) $display("FAIL rand ready_o %0d: got %b want %b", i, ro, exp_ready()); else passed++;
         total++; if (vo !== exp_valid()) $display("FAIL rand valid_o %0d: got %b want %b", i, vo, exp_valid()); else passed++;
         total++; if (occ !== 2'(q.size())) $display("FAIL rand occupancy %0d: got %0d want %0d", i, occ, q.size()); else passed++;
         total++; if (err !== 1'b0) $display("FAIL rand err_o %0d: got %b want 0", i, err); else passed++;
         if (exp_valid()) begin
            total++; if (dout !== q[0].d) $display("FAIL rand data_o %0d: got %h want %h", i, dout, q[0].d); else passed++;
         end
         tick();
      end
      flush = 1'b0;
   endtask
`ifdef PRIM_FLOP_PIPE_DUP_EN
   task automatic test_dup();
      logic [W-1:0] t;
      do_reset();
      ready = 1'b0; valid = 1'b1; din = 32'h9;
      tick();
      tick();
      valid = 1'b0;
      #1;
      total++; if (err !== 1'b0) $display("FAIL dup err before: got %b want 0", err); else passed++;
      t = dut.d[D-1];
      force dut.d[D-1] = t ^ 32'h1;
      @(posedge clk);
      #1;
      release dut.d[D-1];
      total++; if (err !== 1'b1) $display("FAIL dup err set: got %b want 1", err); else passed++;
      repeat (3) @(posedge clk);
      #1;
      total++; if (err !== 1'b1) $display("FAIL dup err sticky: got %b want 1", err); else passed++;
      do_reset();
      #1;
      total++; if (err !== 1'b0) $display("FAIL dup err after reset: got %b want 0", err); else passed++;
   endtask
`endif
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
`ifdef PRIM_FLOP_PIPE_DUP_EN
      test_dup();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/prim_flop_pipe_en.md
# prim_flop_pipe_en

Parametrised elastic pipeline register. It generalises the single enable flop into a `Depth`-stage chain of `Width`-bit registers with per-stage valid bits and a valid/ready handshake on both sides. Bubbles collapse under backpressure, and a synchronous flush drops all contents. It sits on timing-critical datapaths such as fetch-to-decode and LSU response paths, where a retimable, stallable register slice is needed instead of a bare enable flop.

## Interface
- `Width`, 32, data width in bits (≥1)
- `Depth`, 2, number of register stages (≥1)
- `ResetValue`, '0, `Width`-bit reset value of every data stage
- `EnSecBuf`, 0, when 1 each stage load enable passes through `prim_sec_anchor_buf`
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `flush_i`  in  1  synchronous flush of all stages
- `valid_i`  in  1  input beat valid
- `ready_o`  out  1  pipeline can accept a beat this cycle
- `data_i`  in  `Width`  input beat data
- `valid_o`  out  1  output beat valid
- `ready_i`  in  1  downstream accepts output beat
- `data_o`  out  `Width`  output beat data
- `occupancy_o`  out  `$clog2(Depth+1)`  number of valid stages
- `err_o`  out  1  duplicate-register mismatch, sticky

## Operation
- State per stage k (0 = input side, `Depth`-1 = output side): `v[k]` and `d[k]`.
- Load enable: `en[Depth-1] = !v[Depth-1] | ready_i`; `en[k] = !v[k] | en[k+1]`.
- `ready_o = en[0] & !flush_i`.
- On `en[k]`:
  - `v[k]` takes the source valid (`valid_i & !flush_i` for k=0, `v[k-1]` otherwise).
  - `d[k]` takes the source data only when the source valid is 1. Otherwise `d[k]` holds (no toggle on bubbles).
- Without `en[k]`, the stage holds.
- A stage that is empty accepts a beat even when downstream is stalled, so bubbles collapse.
- `valid_o = v[Depth-1]`, `data_o = d[Depth-1]`.
- `occupancy_o` is the population count of `v`, derived combinationally.
- Flush:
  - `flush_i = 1` clears all `v` at the next edge.
  - Data registers hold.
  - `valid_i` is ignored that cycle.
  - Flush overrides a simultaneous input beat and a simultaneous output handshake. The output beat visible that cycle is still consumed if `ready_i = 1`, but nothing new is loaded.
- Reset values:
  - All `v` = 0, all `d` = `ResetValue`.
  - `valid_o` = 0, `data_o` = `ResetValue`, `occupancy_o` = 0, `err_o` = 0.
  - `ready_o` = 1 (pipeline empty).
- Reset mid-operation: all beats are lost immediately (async). No partial beat appears at the output.
- `valid_i` must not depend combinationally on `ready_o`. The pipeline does not depend on `valid_i` to drive `ready_o`, so no combinational loop exists.

## Timing
- Latency: a beat accepted at edge t is presented on `valid_o`/`data_o` after edge t+`Depth`-1, i.e. `Depth` cycles from presentation on `data_i` when unstalled.
- Throughput: 1 beat/cycle sustained when `ready_i` = 1.
- Capacity: `Depth` beats. When full with `ready_i = 0`, `ready_o` = 0 in the same cycle.
- The `ready_i` to `ready_o` path is combinational through the `en` chain, with depth proportional to `Depth`.
- Simultaneous accept and output handshake when full: both occur, and occupancy is unchanged.
- `err_o` asserts the cycle after a mismatch is present and stays high until reset.

## Configuration
- Macro: `PRIM_FLOP_PIPE_DUP_EN`.
- Defined:
  - Every `v` and `d` register has a shadow copy loaded with identical enable and source.
  - Any bitwise difference between primary and shadow sets a registered sticky `err_o`.
  - The shadow copies are reset like the primaries.
- Undefined: no shadow registers; `err_o` is tied to 0.

## Test plan
- Reset then idle (`Width`=32, `Depth`=2) -> `valid_o`=0, `data_o`=0, `ready_o`=1, `occupancy_o`=0, `err_o`=0.
- Stream 0x1..0x8 with `ready_i`=1 -> `valid_o` rises 2 cycles after the first beat, then data 0x1..0x8 in order on consecutive cycles, no gaps.
- Hold `ready_i`=0, send 0xA, 0xB, 0xC -> two beats accepted, `ready_o`=0 on the third, `occupancy_o`=2. Release `ready_i` -> 0xA, 0xB, 0xC emerge in order and 0xC is accepted the cycle `ready_i` rises.
- Fill 2 beats, assert `flush_i` with `valid_i`=1 (0xD) -> next cycle `occupancy_o`=0, `valid_o`=0, 0xD never emerges.
- Assert `rst_ni`=0 with 2 beats in flight, mid-cycle -> `valid_o` drops immediately, `data_o`=`ResetValue`.
- With `PRIM_FLOP_PIPE_DUP_EN` defined, force a bit flip on the primary `d[Depth-1]` -> `err_o`=1 the next cycle and it remains 1 until reset.
